// File: rtl/ahb_master_req_pkg.sv
// Shared types and constants for the AHB master request agent (package ahb_pkg).
package ahb_pkg;

  localparam int BEAT_W = 5;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_OWN,
    ST_RESUME
  } state_e;

  // A zero-length request still moves one beat.
  function automatic logic [BEAT_W-1:0] effBeats(input logic [BEAT_W-1:0] beats);
    return (beats == '0) ? BEAT_W'(1) : beats;
  endfunction

endpackage

// File: rtl/ahb_master_req_if.sv
// Local-core request and AHB arbiter/slave signals of one master request agent.
interface ahb_master_req_if;
  import ahb_pkg::*;

  logic              req_valid;
  logic              req_lock;
  logic [BEAT_W-1:0] req_beats;
  logic              req_ready;
  logic              HBUSREQ;
  logic              HLOCK;
  logic              HGRANT;
  logic              HREADY;
  logic [1:0]        HRESP;
  logic [3:0]        HMASTER;
  logic              bus_own;
  logic              beat_done;
  logic              xfer_done;
  logic              xfer_err;

  modport master (
    input  req_valid, req_lock, req_beats, HGRANT, HREADY, HRESP, HMASTER,
    output req_ready, HBUSREQ, HLOCK, bus_own, beat_done, xfer_done, xfer_err
  );

  modport slave (
    output req_valid, req_lock, req_beats, HGRANT, HREADY, HRESP, HMASTER,
    input  req_ready, HBUSREQ, HLOCK, bus_own, beat_done, xfer_done, xfer_err
  );

endinterface

// File: rtl/ahb_master_req_grant_timer.sv
// ahb_grant_timer: counts consecutive grant-wait cycles; only built when
// AHB_MASTER_REQ_TIMEOUT_EN is defined.
`ifdef AHB_MASTER_REQ_TIMEOUT_EN
module ahb_grant_timer #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] count_q;

  // Fires on the TIMEOUT_CYC-th consecutive enabled cycle.
  assign expired_o = count_en_i && (count_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (!count_en_i || expired_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/ahb_master_req.sv
// AHB master request agent: bus request/lock, grant tracking and beat accounting.
// Define AHB_MASTER_REQ_TIMEOUT_EN to abort requests whose grant never arrives.
module ahb_master_req
  import ahb_pkg::*;
#(
  parameter logic [3:0]  MASTER_ID   = 4'd0,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_master_req_if.master bus
);

  localparam logic [BEAT_W-1:0] ONE_BEAT = BEAT_W'(1);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] remaining_q, remaining_d;
  logic              lock_q, lock_d;

  logic reqReady_q, reqReady_d;
  logic hbusreq_q, hbusreq_d;
  logic hlock_q, hlock_d;
  logic busOwn_q, busOwn_d;
  logic beatDone_q, beatDone_d;
  logic xferDone_q, xferDone_d;
  logic xferErr_q, xferErr_d;

  logic grantHit;
  logic timeoutHit;

`ifdef AHB_MASTER_REQ_TIMEOUT_EN
  ahb_grant_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_grant_timer (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .count_en_i (state_q == ST_REQ),
    .expired_o  (timeoutHit)
  );
`else
  // Without the timer a request waits for its grant forever.
  assign timeoutHit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  assign grantHit = bus.HGRANT && bus.HREADY && (bus.HMASTER == MASTER_ID);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lock_d      = lock_q;
    beatDone_d  = 1'b0;
    xferDone_d  = 1'b0;
    xferErr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          lock_d      = bus.req_lock;
          remaining_d = effBeats(bus.req_beats);
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (grantHit) begin
          state_d = ST_OWN;
        end else if (timeoutHit) begin
          xferErr_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (bus.HREADY) begin
          if (bus.HRESP == HRESP_OKAY) begin
            beatDone_d = 1'b1;
            // The final beat completes even if the grant is withdrawn with it.
            if (remaining_q <= ONE_BEAT) begin
              xferDone_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              remaining_d = remaining_q - ONE_BEAT;
              if (!bus.HGRANT && !lock_q) begin
                state_d = ST_REQ;
              end
            end
          end
        end else begin
          case (bus.HRESP)
            HRESP_RETRY, HRESP_SPLIT: state_d = ST_RESUME;
            HRESP_ERROR: begin
              xferErr_d = 1'b1;
              state_d   = ST_IDLE;
            end
            default: ;
          endcase
        end
      end
      ST_RESUME: state_d = ST_REQ;
      default:   state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      remaining_d = '0;
      lock_d      = 1'b0;
    end

    // Outputs are decoded from the next state so they register with it.
    reqReady_d = (state_d == ST_IDLE);
    busOwn_d   = (state_d == ST_OWN);
    hbusreq_d  = (state_d == ST_REQ) || (state_d == ST_RESUME) ||
                 ((state_d == ST_OWN) && (remaining_d > ONE_BEAT));
    hlock_d    = lock_d;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      lock_q      <= 1'b0;
      reqReady_q  <= 1'b1;
      hbusreq_q   <= 1'b0;
      hlock_q     <= 1'b0;
      busOwn_q    <= 1'b0;
      beatDone_q  <= 1'b0;
      xferDone_q  <= 1'b0;
      xferErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lock_q      <= lock_d;
      reqReady_q  <= reqReady_d;
      hbusreq_q   <= hbusreq_d;
      hlock_q     <= hlock_d;
      busOwn_q    <= busOwn_d;
      beatDone_q  <= beatDone_d;
      xferDone_q  <= xferDone_d;
      xferErr_q   <= xferErr_d;
    end
  end

  assign bus.req_ready = reqReady_q;
  assign bus.HBUSREQ   = hbusreq_q;
  assign bus.HLOCK     = hlock_q;
  assign bus.bus_own   = busOwn_q;
  assign bus.beat_done = beatDone_q;
  assign bus.xfer_done = xferDone_q;
  assign bus.xfer_err  = xferErr_q;

endmodule

// File: tb/tb_ahb_master_req.sv
// Bench for ahb_master_req: directed bus scenarios plus randomized transfers
// scored against an event-sequence model of each transfer.
module tb_ahb_master_req;
  import ahb_pkg::*;

  localparam logic [3:0] MID = 4'd5;
  localparam int EV_BEAT = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int tests = 0;
  int fails = 0;
  int expQ[$];

  bit envMode = 1'b0;
  logic dReady = 1'b1, dGrant = 1'b0;
  logic [1:0] dResp = 2'd0;
  logic [3:0] dMaster = 4'd0;
  logic eReady = 1'b1, eGrant = 1'b0;
  logic [1:0] eResp = 2'd0;
  logic [3:0] eMaster = 4'd0;

  int txnSeq = 0;
  int injectAt = 0;
  bit injectOn = 1'b0;
  logic [1:0] injectResp = 2'd0;

  ahb_master_req_if bus();

  ahb_master_req #(
    .MASTER_ID   (MID),
    .TIMEOUT_CYC (8)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.master)
  );

  assign bus.HREADY  = envMode ? eReady  : dReady;
  assign bus.HRESP   = envMode ? eResp   : dResp;
  assign bus.HGRANT  = envMode ? eGrant  : dGrant;
  assign bus.HMASTER = envMode ? eMaster : dMaster;

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Reference model: a transfer is an ordered list of beat/done/error events.
  function automatic void pushTxn(input int beats, input int errAt);
    int eff = (beats == 0) ? 1 : beats;
    if (errAt > 0) begin
      for (int i = 1; i < errAt; i++) expQ.push_back(EV_BEAT);
      expQ.push_back(EV_ERR);
    end else begin
      for (int i = 0; i < eff; i++) expQ.push_back(EV_BEAT);
      expQ.push_back(EV_DONE);
    end
  endfunction

  task automatic applyStimulus(input int beats, input bit lk);
    bus.req_valid = 1'b1;
    bus.req_beats = BEAT_W'(beats);
    bus.req_lock  = lk;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic waitReady(input int budget, input string name);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({name, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic popCheck(input int kind, input string name);
    int want;
    tests++;
    if (expQ.size() == 0) begin
      fails++;
      $display("[TB] FAIL sb_%s: got unexpected pulse, expected no event", name);
    end else begin
      want = expQ.pop_front();
      if (want != kind) begin
        fails++;
        $display("[TB] FAIL sb_%s: got event %0d, expected event %0d", name, kind, want);
      end
    end
  endtask

  // Monitor: every observed pulse consumes the next modelled event.
  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESETn) begin
        if (bus.beat_done) popCheck(EV_BEAT, "beat_done");
        if (bus.xfer_done) popCheck(EV_DONE, "xfer_done");
        if (bus.xfer_err)  popCheck(EV_ERR, "xfer_err");
      end
    end
  end

  // Random arbiter and slave reacting to the agent's bus activity.
  initial begin
    int seenSeq = 0;
    int envBeat = 0;
    int denyCnt = 0;
    bit injectPending = 1'b0;
    bit secondPhase = 1'b0;
    logic [1:0] pendingResp = 2'd0;
    forever begin
      @(negedge HCLK);
      if (txnSeq != seenSeq) begin
        seenSeq = txnSeq;
        envBeat = 0;
        injectPending = injectOn;
      end
      if (envMode) begin
        if (secondPhase) begin
          eReady = 1'b1;
          eResp = pendingResp;
          secondPhase = 1'b0;
        end else if (bus.bus_own && injectPending && envBeat == injectAt - 1) begin
          eReady = 1'b0;
          eResp = injectResp;
          pendingResp = injectResp;
          secondPhase = 1'b1;
          injectPending = 1'b0;
        end else if (bus.bus_own && $urandom_range(0, 3) == 0) begin
          eReady = 1'b0;
          eResp = HRESP_OKAY;
        end else begin
          eReady = 1'b1;
          eResp = HRESP_OKAY;
          if (bus.bus_own) envBeat++;
        end
        if (bus.HBUSREQ && (denyCnt >= 3 || $urandom_range(0, 2) != 0)) begin
          eGrant = 1'b1;
          eMaster = MID;
          denyCnt = 0;
        end else begin
          eGrant = 1'b0;
          eMaster = MID ^ 4'($urandom_range(1, 15));
          if (bus.HBUSREQ) denyCnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, eff, kind, at;
    bit lk;

    bus.req_valid = 1'b0;
    bus.req_lock  = 1'b0;
    bus.req_beats = '0;

    #12;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_hbusreq",   32'(bus.HBUSREQ),   32'd0);
    checkOutput("rst_hlock",     32'(bus.HLOCK),     32'd0);
    checkOutput("rst_bus_own",   32'(bus.bus_own),   32'd0);
    checkOutput("rst_pulses",    {29'd0, bus.beat_done, bus.xfer_done, bus.xfer_err}, 32'd0);
    tick();
    HRESETn = 1'b1;
    tick();

    // Four-beat burst, grant three cycles after acceptance.
    pushTxn(4, 0);
    applyStimulus(4, 1'b0);
    checkOutput("b4_hbusreq_after_accept", 32'(bus.HBUSREQ), 32'd1);
    checkOutput("b4_req_ready_busy", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    dGrant = 1'b1;
    dMaster = MID;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkOutput($sformatf("b4_bus_own_c%0d", c), 32'(bus.bus_own), 32'd1);
      checkOutput($sformatf("b4_hbusreq_c%0d", c), 32'(bus.HBUSREQ), (c < 4) ? 32'd1 : 32'd0);
    end
    tick();
    checkOutput("b4_idle_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("b4_idle_hbusreq", 32'(bus.HBUSREQ), 32'd0);
    dGrant = 1'b0;
    tick();
    checkOutput("b4_sb_drained", 32'(expQ.size()), 32'd0);

    // Locked five-beat burst keeps the bus when the grant is withdrawn.
    pushTxn(5, 0);
    dGrant = 1'b1;
    applyStimulus(5, 1'b1);
    checkOutput("lk_hlock_req", 32'(bus.HLOCK), 32'd1);
    tick();
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("lk_bus_own_c%0d", c), 32'(bus.bus_own), 32'd1);
      checkOutput($sformatf("lk_hlock_c%0d", c), 32'(bus.HLOCK), 32'd1);
      dGrant = 1'b0;
      dMaster = 4'd2;
      tick();
    end
    checkOutput("lk_idle_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("lk_idle_hlock", 32'(bus.HLOCK), 32'd0);
    tick();
    checkOutput("lk_sb_drained", 32'(expQ.size()), 32'd0);

    // Reset during the second beat of a locked burst.
    expQ.push_back(EV_BEAT);
    dGrant = 1'b1;
    dMaster = MID;
    applyStimulus(4, 1'b1);
    tick();
    tick();
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("mid_rst_hbusreq", 32'(bus.HBUSREQ), 32'd0);
    checkOutput("mid_rst_hlock", 32'(bus.HLOCK), 32'd0);
    checkOutput("mid_rst_bus_own", 32'(bus.bus_own), 32'd0);
    checkOutput("mid_rst_pulses", {29'd0, bus.beat_done, bus.xfer_done, bus.xfer_err}, 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    dGrant = 1'b0;
    tick();
    HRESETn = 1'b1;
    tick();
    checkOutput("mid_rst_ready_after", 32'(bus.req_ready), 32'd1);
    checkOutput("mid_rst_sb_drained", 32'(expQ.size()), 32'd0);

    // Grant withheld indefinitely.
`ifdef AHB_MASTER_REQ_TIMEOUT_EN
    expQ.push_back(EV_ERR);
    applyStimulus(2, 1'b0);
    repeat (7) tick();
    checkOutput("to_still_req_hbusreq", 32'(bus.HBUSREQ), 32'd1);
    checkOutput("to_still_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    checkOutput("to_xfer_err", 32'(bus.xfer_err), 32'd1);
    checkOutput("to_idle_ready", 32'(bus.req_ready), 32'd1);
    tick();
`else
    applyStimulus(2, 1'b0);
    repeat (20) tick();
    checkOutput("nto_hbusreq", 32'(bus.HBUSREQ), 32'd1);
    checkOutput("nto_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("nto_bus_own", 32'(bus.bus_own), 32'd0);
    pushTxn(2, 0);
    dGrant = 1'b1;
    dMaster = MID;
    waitReady(50, "nto");
    tick();
    dGrant = 1'b0;
`endif
    checkOutput("grant_wait_sb_drained", 32'(expQ.size()), 32'd0);

    // Randomized transfers with wait states, grant loss and RETRY/SPLIT/ERROR.
    envMode = 1'b1;
    for (int t = 0; t < 40; t++) begin
      n = (t == 0) ? 0 : (t == 1) ? 31 : int'($urandom_range(0, 31));
      eff = (n == 0) ? 1 : n;
      kind = int'($urandom_range(0, 3));
      at = int'($urandom_range(1, eff));
      lk = 1'($urandom_range(0, 1));
      injectOn = (kind != 0);
      injectAt = at;
      injectResp = (kind == 1) ? HRESP_SPLIT : (kind == 2) ? HRESP_ERROR : HRESP_RETRY;
      txnSeq++;
      pushTxn(n, (kind == 2) ? at : 0);
      applyStimulus(n, lk);
      waitReady(3000, $sformatf("rand%0d", t));
      tick();
      checkOutput($sformatf("rand%0d_sb_drained", t), 32'(expQ.size()), 32'd0);
    end
    envMode = 1'b0;
    tick();

    checkOutput("final_sb_empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_master_req.md
AHB_MASTER_REQ -- requirements
Module: ahb_master_req

Interface
REQ-001 Parameter MASTER_ID, default 0, meaning the 4-bit master index this agent represents on HMASTER.
REQ-002 Parameter TIMEOUT_CYC, default 256, meaning grant-wait limit in HCLK cycles (used only with AHB_MASTER_REQ_TIMEOUT_EN).
REQ-003 HCLK  in  1  bus clock; all state changes on rising edge.
REQ-004 HRESETn  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  local core requests a transfer.
REQ-006 req_lock  in  1  transfer is locked (sampled with req_valid).
REQ-007 req_beats  in  5  number of data beats, 1..31; 0 is treated as 1.
REQ-008 req_ready  out  1  agent idle, request acceptable.
REQ-009 HBUSREQ  out  1  bus request to arbiter (one bit of the arbiter's HBUSREQx).
REQ-010 HLOCK  out  1  lock request to arbiter.
REQ-011 HGRANT  in  1  grant from arbiter.
REQ-012 HREADY  in  1  bus ready.
REQ-013 HRESP  in  2  slave response: OKAY=0, ERROR=1, RETRY=2, SPLIT=3.
REQ-014 HMASTER  in  4  current bus owner from arbiter.
REQ-015 bus_own  out  1  agent owns the bus (state OWN).
REQ-016 beat_done  out  1  one-cycle pulse per completed OKAY beat.
REQ-017 xfer_done  out  1  one-cycle pulse when the final beat completes.
REQ-018 xfer_err  out  1  one-cycle pulse on ERROR abort or grant timeout.

Function
REQ-019 States SHALL be IDLE, REQ, OWN, RESUME; all outputs registered.
REQ-020 req_ready SHALL be high exactly in IDLE; req_valid outside IDLE SHALL be ignored.
REQ-021 IDLE with req_valid at edge: SHALL latch req_lock and remaining=max(req_beats,1), go to REQ.
REQ-022 HBUSREQ SHALL be high in REQ and RESUME, and in OWN while remaining>1; low otherwise.
REQ-023 HLOCK SHALL equal latched lock in REQ, RESUME, OWN; low in IDLE.
REQ-024 REQ: edge with HGRANT=1, HREADY=1 and HMASTER==MASTER_ID SHALL go to OWN; otherwise stay.
REQ-025 OWN: edge with HREADY=1 and HRESP=OKAY SHALL pulse beat_done and decrement remaining; at remaining==1 SHALL pulse xfer_done and go to IDLE.
REQ-026 OWN: edge with HREADY=0 and HRESP=RETRY or SPLIT SHALL go to RESUME, remaining unchanged, no beat counted.
REQ-027 OWN: edge with HREADY=0 and HRESP=ERROR SHALL pulse xfer_err and go to IDLE.
REQ-028 OWN, unlocked: edge with HREADY=1, HRESP=OKAY, HGRANT=0 and remaining>1 SHALL count the beat then go to REQ (grant lost); locked transfers SHALL stay in OWN.
REQ-029 RESUME SHALL wait one cycle (second response cycle) then go to REQ.
REQ-030 Simultaneous final beat and HGRANT=0: final beat wins, go to IDLE.

Reset
REQ-031 HRESETn low SHALL asynchronously force IDLE, remaining=0, latched lock=0, all outputs 0 except req_ready=1.
REQ-032 Reset mid-transfer SHALL drop HBUSREQ/HLOCK immediately with no done or error pulse.

Configuration
REQ-033 Macro AHB_MASTER_REQ_TIMEOUT_EN defined: counter counts cycles in REQ; reaching TIMEOUT_CYC SHALL pulse xfer_err and go to IDLE; counter clears on leaving REQ.
REQ-034 Macro undefined: no counter, REQ waits indefinitely, TIMEOUT_CYC unused.

Structure
REQ-035 Package ahb_pkg SHALL hold the HRESP enum, the state typedef and the beat-width constant (5).
REQ-036 Timeout counter SHALL be sub-module ahb_grant_timer, instantiated only under AHB_MASTER_REQ_TIMEOUT_EN.

Verification
REQ-037 req_beats=4, grant after 3 cycles, HREADY=1, OKAY -> HBUSREQ high 1 cycle after accept, 4 beat_done, xfer_done with 4th, HBUSREQ low from 4th beat.
REQ-038 req_beats=3, SPLIT after beat 1 (HREADY=0 two cycles) -> RESUME, REQ, re-grant, exactly 2 further beat_done, single xfer_done.
REQ-039 req_lock=1, req_beats=5, HGRANT dropped mid-burst -> stays OWN, HLOCK high throughout, 5 beats complete.
REQ-040 ERROR on beat 2 of 4 -> xfer_err pulse, IDLE, req_ready=1, no xfer_done.
REQ-041 HRESETn low during OWN beat 2 -> all outputs 0 same cycle, req_ready=1 after release.
REQ-042 Timeout build, TIMEOUT_CYC=8, HGRANT held 0 -> xfer_err after 8 cycles in REQ, IDLE; non-timeout build stays in REQ.
